// File: rtl/scr1_dmem_tcm_resp_pkg.sv
// Shared SCR1 memory interface types used by the DMEM TCM responder and its lane helper.
// Command, width and response encodings match the core-side DMEM port.
package scr1_dmem_tcm_resp_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_dmem_lane_align.sv
// Byte-lane steering for a 32-bit DMEM slave: store byte enables / replicated write data,
// and right-alignment with zero extension of load data. Purely combinational.
module scr1_dmem_lane_align
  import scr1_dmem_tcm_resp_pkg::*;
(
  input  type_scr1_mem_width_e st_width_i,
  input  logic [1:0]           st_offset_i,
  input  logic [31:0]          st_wdata_i,
  output logic [3:0]           st_be_o,
  output logic [31:0]          st_wdata_o,
  input  type_scr1_mem_width_e ld_width_i,
  input  logic [1:0]           ld_offset_i,
  input  logic [31:0]          ld_rdata_i,
  output logic [31:0]          ld_rdata_o
);

  logic [31:0] ldShifted;

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    st_be_o    = 4'b0000;
    st_wdata_o = 32'h0;
    case (st_width_i)
      SCR1_MEM_WIDTH_BYTE: begin
        st_be_o    = 4'b0001 << st_offset_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      SCR1_MEM_WIDTH_HWORD: begin
        st_be_o    = 4'b0011 << st_offset_i;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      SCR1_MEM_WIDTH_WORD: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_wdata_i;
      end
      default: begin
        st_be_o    = 4'b0000;
        st_wdata_o = 32'h0;
      end
    endcase
  end

  always_comb begin
    ldShifted  = ld_rdata_i >> {ld_offset_i, 3'b000};
    ld_rdata_o = 32'h0;
    case (ld_width_i)
      SCR1_MEM_WIDTH_BYTE:  ld_rdata_o = {24'h0, ldShifted[7:0]};
      SCR1_MEM_WIDTH_HWORD: ld_rdata_o = {16'h0, ldShifted[15:0]};
      SCR1_MEM_WIDTH_WORD:  ld_rdata_o = ldShifted;
      default:              ld_rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/scr1_dmem_tcm_resp.sv
// DMEM responder in front of a single-port synchronous TCM SRAM: one request in flight,
// range/alignment checking, and a single RDY_OK/RDY_ER response after 1+WAIT_STATES cycles.
module scr1_dmem_tcm_resp
  import scr1_dmem_tcm_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hF000_0000,
  parameter int          SIZE_LOG2   = 14,
  parameter int          WAIT_STATES = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dmem_req_i,
  input  type_scr1_mem_cmd_e          dmem_cmd_i,
  input  type_scr1_mem_width_e        dmem_width_i,
  input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr_i,
  input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata_i,
  output logic                        dmem_req_ack_o,
  output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata_o,
  output type_scr1_mem_resp_e         dmem_resp_o,
  output logic                        sram_cs_o,
  output logic                        sram_we_o,
  output logic [3:0]                  sram_be_o,
  output logic [SIZE_LOG2-3:0]        sram_addr_o,
  output logic [31:0]                 sram_wdata_o,
  input  logic [31:0]                 sram_rdata_i
);

  localparam logic [2:0] WS_CNT = 3'(WAIT_STATES);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [1:0]           offset_q, offset_d;
  type_scr1_mem_width_e width_q, width_d;
  type_scr1_mem_cmd_e   cmd_q, cmd_d;
  logic [31:0]          rdata_q, rdata_d;

  logic        accept, reqErr, misaligned, widthBad, outOfRange, respCycle, sramAccess;
  logic [3:0]  stBe;
  logic [31:0] stWdata, ldRdata, rdataSel;

  assign accept     = ~rst & (state_q == IDLE) & dmem_req_i;
  assign outOfRange = dmem_addr_i[31:SIZE_LOG2] != BASE_ADDR[31:SIZE_LOG2];
  assign reqErr     = misaligned | widthBad | outOfRange;
  assign sramAccess = accept & ~reqErr;
  assign respCycle  = ~rst & (state_q == BUSY) & (cnt_q == 3'd0);

  always_comb begin
    misaligned = 1'b0;
    widthBad   = 1'b0;
    case (dmem_width_i)
      SCR1_MEM_WIDTH_BYTE:  misaligned = 1'b0;
      SCR1_MEM_WIDTH_HWORD: misaligned = dmem_addr_i[0];
      SCR1_MEM_WIDTH_WORD:  misaligned = |dmem_addr_i[1:0];
      default:              widthBad   = 1'b1;
    endcase
  end

  scr1_dmem_lane_align u_lane_align (
    .st_width_i  (dmem_width_i),
    .st_offset_i (dmem_addr_i[1:0]),
    .st_wdata_i  (dmem_wdata_i),
    .st_be_o     (stBe),
    .st_wdata_o  (stWdata),
    .ld_width_i  (width_q),
    .ld_offset_i (offset_q),
    .ld_rdata_i  (sram_rdata_i),
    .ld_rdata_o  (ldRdata)
  );

  // The first BUSY cycle is the one where the counter still holds its load value;
  // that is when the SRAM read data is valid and gets captured.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    offset_d = offset_q;
    width_d  = width_q;
    cmd_d    = cmd_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (dmem_req_i) begin
          state_d  = BUSY;
          cnt_d    = WS_CNT;
          err_d    = reqErr;
          offset_d = dmem_addr_i[1:0];
          width_d  = dmem_width_i;
          cmd_d    = dmem_cmd_i;
        end
      end
      BUSY: begin
        if (cnt_q == WS_CNT) rdata_d = ldRdata;
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      err_q    <= 1'b0;
      offset_q <= 2'b00;
      width_q  <= SCR1_MEM_WIDTH_BYTE;
      cmd_q    <= SCR1_MEM_CMD_RD;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      offset_q <= offset_d;
      width_q  <= width_d;
      cmd_q    <= cmd_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dmem_req_ack_o = ~rst & (state_q == IDLE);
  assign sram_cs_o      = sramAccess;
  assign sram_we_o      = sramAccess & (dmem_cmd_i == SCR1_MEM_CMD_WR);
  assign sram_be_o      = sramAccess ? stBe : 4'b0000;
  assign sram_addr_o    = sramAccess ? dmem_addr_i[SIZE_LOG2-1:2] : '0;
  assign sram_wdata_o   = sramAccess ? stWdata : 32'h0;

  // With no wait states the response cycle is the read-data cycle, so bypass the register.
  assign rdataSel     = (WAIT_STATES == 0) ? ldRdata : rdata_q;
  assign dmem_resp_o  = respCycle ? (err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK)
                                  : SCR1_MEM_RESP_NOTRDY;
  assign dmem_rdata_o = (respCycle & ~err_q & (cmd_q == SCR1_MEM_CMD_RD)) ? rdataSel : '0;

endmodule
